// File: rtl/wb_queue_pkg.sv
// Shared processor constants and the write-queue entry type for the
// register-file writeback path.
package wb_queue_pkg;
  localparam int REG_W     = 5;
  localparam int DATA_W    = 32;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue_if.sv
// Writeback-queue bus: ALU and multdiv result inputs, register-file write
// outputs and the pending-write probe.
interface wb_queue_if
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) ();
  logic                    alu_valid;
  logic [REG_W-1:0]        alu_reg;
  logic [DATA_W-1:0]       alu_data;
  logic                    md_valid;
  logic [REG_W-1:0]        md_reg;
  logic [DATA_W-1:0]       md_data;
  logic                    md_ready;
  logic [REG_W-1:0]        query_reg;
  logic                    query_busy;
  logic                    ctrl_writeEnable;
  logic [REG_W-1:0]        ctrl_writeReg;
  logic [DATA_W-1:0]       data_writeReg;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport slave (
    input  alu_valid, alu_reg, alu_data, md_valid, md_reg, md_data, query_reg,
    output md_ready, query_busy, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           fifo_count
  );

  modport master (
    output alu_valid, alu_reg, alu_data, md_valid, md_reg, md_data, query_reg,
    input  md_ready, query_busy, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           fifo_count
  );
endinterface

// File: rtl/wb_queue_fifo.sv
// Multdiv write queue: entry storage, wrapping pointers, occupancy count and
// per-entry live bits that an overtaking ALU write can clear.
module wb_fifo
  import wb_queue_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             i_push,
  input  wb_entry_t        i_push_entry,
  input  logic             i_pop,
  input  logic             i_kill,
  input  logic [REG_W-1:0] i_kill_reg,
  input  logic [REG_W-1:0] i_query_reg,
  output wb_entry_t        o_head,
  output logic             o_head_live,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_query_busy
);
  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_live;

  assign w_push_live = !(i_kill && (i_push_entry.rd == i_kill_reg));

  // NOTE: payload storage is not reset; the live bits alone say which entries matter.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  // NOTE: later non-blocking assignments win, so pop/push updates override the kill scan.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_live   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill && (r_mem[i].rd == i_kill_reg)) r_live[i] <= 1'b0;
      end
      if (i_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + PTR_W'(1);
      end
      if (i_push) begin
        r_live[r_wr_ptr] <= w_push_live;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // NOTE: default assigned first so the loop cannot infer a latch.
  always_comb begin
    o_query_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_mem[i].rd == i_query_reg)) o_query_busy = 1'b1;
    end
    if (i_query_reg == '0) o_query_busy = 1'b0;
  end

  assign o_head      = r_mem[r_rd_ptr];
  assign o_head_live = r_live[r_rd_ptr];
  assign o_count     = r_count;
  assign o_full      = (r_count == CNT_W'(DEPTH));
endmodule

// File: rtl/wb_queue.sv
// Register-file writeback arbiter: ALU results issue immediately, multdiv
// results wait in wb_fifo and drain in cycles the ALU leaves free.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic       clock,
  input  logic       ctrl_reset,
  wb_queue_if.slave  bus
);
  logic                   w_alu_issue;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_head_live;
  logic                   w_query_busy;
  wb_entry_t              w_head;
  wb_entry_t              w_md_entry;
  logic [$clog2(DEPTH):0] w_count;

  logic                   r_we;
  logic [REG_W-1:0]       r_wreg;
  logic [DATA_W-1:0]      r_wdata;

  assign w_alu_issue = bus.alu_valid && (bus.alu_reg != '0);
  assign w_push      = bus.md_valid && !w_full && (bus.md_reg != '0);
  assign w_pop       = !w_alu_issue && (w_count != '0);
  assign w_md_entry  = '{rd: bus.md_reg, data: bus.md_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .i_push       (w_push),
    .i_push_entry (w_md_entry),
    .i_pop        (w_pop),
    .i_kill       (w_alu_issue),
    .i_kill_reg   (bus.alu_reg),
    .i_query_reg  (bus.query_reg),
    .o_head       (w_head),
    .o_head_live  (w_head_live),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_query_busy (w_query_busy)
  );

  // A killed head still consumes its pop slot but issues nothing.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else if (w_alu_issue) begin
      r_we    <= 1'b1;
      r_wreg  <= bus.alu_reg;
      r_wdata <= bus.alu_data;
    end else if (w_pop && w_head_live) begin
      r_we    <= 1'b1;
      r_wreg  <= w_head.rd;
      r_wdata <= w_head.data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign bus.md_ready         = !w_full;
  assign bus.fifo_count       = w_count;
  assign bus.query_busy       = w_query_busy;
  assign bus.ctrl_writeEnable = r_we;
  assign bus.ctrl_writeReg    = r_wreg;
  assign bus.data_writeReg    = r_wdata;
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: write-queue entries (power of two, >=2).
REQ-002 SHALL have port clock  in  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port ctrl_reset  in  1: asynchronous, active-low reset.
REQ-004 SHALL have port alu_valid  in  1: single-cycle result present this cycle.
REQ-005 SHALL have port alu_reg  in  5: ALU destination register.
REQ-006 SHALL have port alu_data  in  32: ALU result.
REQ-007 SHALL have port md_valid  in  1: multdiv result offered.
REQ-008 SHALL have port md_reg  in  5: multdiv destination register.
REQ-009 SHALL have port md_data  in  32: multdiv result.
REQ-010 SHALL have port md_ready  out  1: queue accepts md result this cycle.
REQ-011 SHALL have port query_reg  in  5: register probed for a pending write.
REQ-012 SHALL have port query_busy  out  1: query_reg has a live queued write.
REQ-013 SHALL have port ctrl_writeEnable  out  1: register-file write enable.
REQ-014 SHALL have port ctrl_writeReg  out  5: register-file write address.
REQ-015 SHALL have port data_writeReg  out  32: register-file write data.
REQ-016 SHALL have port fifo_count  out  3: occupied queue slots, 0..DEPTH.

Function
REQ-017 SHALL register ctrl_writeEnable/ctrl_writeReg/data_writeReg, changing only on rising edge, so the falling-edge register file samples stable values.
REQ-018 SHALL issue at most one write per cycle.
REQ-019 SHALL give ALU absolute priority: alu_valid with alu_reg!=0 at edge N -> write of alu_reg/alu_data visible after edge N (latency 1); the ALU is never stalled.
REQ-020 SHALL enqueue {md_reg, md_data} at an edge where md_valid && md_ready && md_reg!=0.
REQ-021 SHALL drive md_ready = (fifo_count < DEPTH) from registered state only; no push at full even if a pop occurs the same edge.
REQ-022 SHALL pop the head at an edge where alu_valid is 0 (or alu_reg==0) and fifo_count>0; a live head issues a write (min md latency 2 cycles), a killed head issues ctrl_writeEnable=0.
REQ-023 SHALL allow push and pop on the same edge; fifo_count unchanged.
REQ-024 SHALL discard writes to register 0 from either source: no enqueue, no issue.
REQ-025 SHALL, when an ALU write to register X issues, clear the live bit of every queue entry with reg X, including one pushed on the same edge.
REQ-026 SHALL drive query_busy combinationally = OR over live entries with reg==query_reg; 0 when query_reg==0.
REQ-027 SHALL keep queue order FIFO; pointers wrap modulo DEPTH.
REQ-028 SHALL drive ctrl_writeEnable=0 in any cycle with no issued write; ctrl_writeReg/data_writeReg hold their last values.

Reset
REQ-029 SHALL on ctrl_reset low asynchronously clear ctrl_writeEnable, ctrl_writeReg, data_writeReg, pointers, fifo_count and all live bits; md_ready=1 follows.
REQ-030 SHALL drop all queued entries on reset mid-operation; no write issues on the first edge after release unless alu_valid.

Structure
REQ-031 SHALL place REG_W=5, DATA_W=32 and DEPTH default in the shared processor package.
REQ-032 SHALL implement storage, pointers, count and live bits in one sub-module wb_fifo; arbitration and issue registers stay in wb_queue.

Verification
REQ-033 SHALL cover: alu_valid, reg 5, 0x1234 -> next cycle WE=1, reg 5, data 0x1234; md idle.
REQ-034 SHALL cover: md pushes reg 7,0xA then reg 8,0xB with ALU idle -> writes 7/0xA then 8/0xB in order, count returns to 0.
REQ-035 SHALL cover: ALU busy every cycle, 5 md offers -> 4 accepted, md_ready=0, count=4; ALU idle -> 4 writes drain.
REQ-036 SHALL cover: queue holds reg 3 (0xDEAD), ALU writes reg 3 (0xBEEF) -> query_busy(3) falls to 0, later pop gives WE=0, final r3=0xBEEF.
REQ-037 SHALL cover: writes to reg 0 from both sources -> WE stays 0, count unchanged.
REQ-038 SHALL cover: reset asserted with count=3 -> outputs 0, count 0, md_ready=1 immediately, no stale write after release.
